// File: rtl/autoconfig_pkg.sv
// Shared encodings for the AUTOCONFIG chain responder: bus phases, register
// nibble offsets, Zorro II size codes and the size-to-64K-units helper.
package autoconfig_pkg;

  // Bus phase encodings produced by the Z2 tracker
  localparam logic [1:0] Z2_IDLE = 2'b00;
  localparam logic [1:0] Z2_ADDR = 2'b01;
  localparam logic [1:0] Z2_DATA = 2'b10;
  localparam logic [1:0] Z2_END  = 2'b11;

  // Nibble offsets within the E8xxxx configuration space (ADDR[8:1])
  localparam logic [7:0] REG_TYPE    = 8'h00;
  localparam logic [7:0] REG_SIZE    = 8'h01;
  localparam logic [7:0] REG_PROD_HI = 8'h02;
  localparam logic [7:0] REG_PROD_LO = 8'h03;
  localparam logic [7:0] REG_FLAGS   = 8'h04;
  localparam logic [7:0] REG_RSVD    = 8'h05;
  localparam logic [7:0] REG_MFG     = 8'h08;
  localparam logic [7:0] REG_SERIAL  = 8'h0C;
  localparam logic [7:0] REG_ROM     = 8'h14;
  localparam logic [7:0] REG_INT0    = 8'h20;
  localparam logic [7:0] REG_INT1    = 8'h21;
  localparam logic [7:0] REG_BASE_HI = 8'h24;
  localparam logic [7:0] REG_BASE_LO = 8'h25;
  localparam logic [7:0] REG_SHUTUP  = 8'h26;

  // Zorro II size codes
  localparam logic [2:0] SIZE_8M   = 3'b000;
  localparam logic [2:0] SIZE_64K  = 3'b001;
  localparam logic [2:0] SIZE_128K = 3'b010;
  localparam logic [2:0] SIZE_256K = 3'b011;
  localparam logic [2:0] SIZE_512K = 3'b100;
  localparam logic [2:0] SIZE_1M   = 3'b101;
  localparam logic [2:0] SIZE_2M   = 3'b110;
  localparam logic [2:0] SIZE_4M   = 3'b111;

  typedef enum logic {StPresent, StDone} ac_state_e;

  // Window length in 64K units; 9 bits so base + units never wraps
  function automatic logic [8:0] size_to_units(input logic [2:0] size);
    logic [8:0] units;
    units = 9'd1;
    case (size)
      SIZE_8M:   units = 9'd128;
      SIZE_64K:  units = 9'd1;
      SIZE_128K: units = 9'd2;
      SIZE_256K: units = 9'd4;
      SIZE_512K: units = 9'd8;
      SIZE_1M:   units = 9'd16;
      SIZE_2M:   units = 9'd32;
      SIZE_4M:   units = 9'd64;
      default:   units = 9'd1;
    endcase
    return units;
  endfunction

endpackage

// File: rtl/autoconfig_chain_read_mux.sv
// Combinational offset-to-nibble lookup for the board currently presented.
module ac_read_mux
  import autoconfig_pkg::*;
#(
  parameter logic [15:0] MFG_ID     = 16'd2011,
  parameter logic [31:0] SERIAL     = 32'd1,
  parameter logic [15:0] ROM_OFFSET = 16'h0008
) (
  input  logic [7:0] offset,
  input  logic       is_mem,
  input  logic       has_rom,
  input  logic [2:0] size,
  input  logic [7:0] prodid,
  output logic [3:0] nibble
);

  // Decode the register nibble; most fields read back inverted
  always_comb begin
    nibble = 4'hF;
    case (offset)
      REG_TYPE:          nibble = {2'b11, is_mem, has_rom};
      REG_SIZE:          nibble = {1'b0, size};
      REG_PROD_HI:       nibble = ~prodid[7:4];
      REG_PROD_LO:       nibble = ~prodid[3:0];
      REG_FLAGS:         nibble = ~{is_mem, 3'b000};
      REG_RSVD:          nibble = 4'hE;
      REG_MFG:           nibble = ~MFG_ID[15:12];
      REG_MFG + 8'd1:    nibble = ~MFG_ID[11:8];
      REG_MFG + 8'd2:    nibble = ~MFG_ID[7:4];
      REG_MFG + 8'd3:    nibble = ~MFG_ID[3:0];
      REG_SERIAL:        nibble = ~SERIAL[31:28];
      REG_SERIAL + 8'd1: nibble = ~SERIAL[27:24];
      REG_SERIAL + 8'd2: nibble = ~SERIAL[23:20];
      REG_SERIAL + 8'd3: nibble = ~SERIAL[19:16];
      REG_SERIAL + 8'd4: nibble = ~SERIAL[15:12];
      REG_SERIAL + 8'd5: nibble = ~SERIAL[11:8];
      REG_SERIAL + 8'd6: nibble = ~SERIAL[7:4];
      REG_SERIAL + 8'd7: nibble = ~SERIAL[3:0];
      REG_ROM:           nibble = has_rom ? ~ROM_OFFSET[15:12] : 4'hF;
      REG_ROM + 8'd1:    nibble = has_rom ? ~ROM_OFFSET[11:8]  : 4'hF;
      REG_ROM + 8'd2:    nibble = has_rom ? ~ROM_OFFSET[7:4]   : 4'hF;
      REG_ROM + 8'd3:    nibble = has_rom ? ~ROM_OFFSET[3:0]   : 4'hF;
      REG_INT0, REG_INT1: nibble = 4'h0;
      default:           nibble = 4'hF;
    endcase
  end

endmodule

// File: rtl/autoconfig_chain.sv
// Zorro II AUTOCONFIG responder presenting several logical boards in turn,
// with per-board runtime enables, base registers and window decode.
module autoconfig_chain
  import autoconfig_pkg::*;
#(
  parameter int unsigned                NUM_BOARDS    = 3,
  parameter logic [15:0]                MFG_ID        = 16'd2011,
  parameter logic [31:0]                SERIAL        = 32'd1,
  parameter logic [NUM_BOARDS*8-1:0]    BOARD_PRODID  = {8'd74, 8'h06, 8'd72},
  parameter logic [NUM_BOARDS*3-1:0]    BOARD_SIZE    = {3'b001, 3'b010, 3'b000},
  parameter logic [NUM_BOARDS-1:0]      BOARD_IS_MEM  = 3'b001,
  parameter logic [NUM_BOARDS-1:0]      BOARD_HAS_ROM = 3'b010,
  parameter logic [15:0]                ROM_OFFSET    = 16'h0008
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [23:1]           ADDR,
  input  logic                  AS_n,
  input  logic                  RW,
  input  logic [3:0]            DIN,
  input  logic [1:0]            z2_state,
  input  logic                  CFGIN,
  input  logic [NUM_BOARDS-1:0] board_en,
  output logic [3:0]            DOUT,
  output logic                  dtack,
  output logic                  autoconfig_cycle,
  output logic                  CFGOUT,
  output logic [NUM_BOARDS-1:0] board_configured,
  output logic [NUM_BOARDS-1:0] board_hit
);

  localparam int unsigned IdxW = (NUM_BOARDS > 1) ? $clog2(NUM_BOARDS) : 1;

  // Lowest enabled board at or above 'start'; MSB flags that one was found
  function automatic logic [IdxW:0] find_from(input logic [NUM_BOARDS-1:0] en,
                                              input int start);
    logic [IdxW:0] r;
    r = '0;
    for (int i = int'(NUM_BOARDS) - 1; i >= 0; i--) begin
      if (i >= start && en[i]) r = {1'b1, IdxW'(i)};
    end
    return r;
  endfunction

  ac_state_e                  state_q, state_d;
  logic [IdxW-1:0]            idx_q, idx_d;
  logic                       dtack_q, cfgin_q, cfgout_q;
  logic [3:0]                 dout_q, staged_q;
  logic [NUM_BOARDS-1:0]      configured_q;
  logic [NUM_BOARDS-1:0][7:0] base_q;

  logic [7:0]    offset;
  logic [8:0]    addr_hi9;
  logic          exec, wr, advance;
  logic [IdxW:0] first_pick, next_pick;
  logic [3:0]    rd_nibble;
  logic          unused_addr_bits;

  assign offset           = ADDR[8:1];
  assign addr_hi9         = {1'b0, ADDR[23:16]};
  assign unused_addr_bits = ^ADDR[15:9];

  assign autoconfig_cycle = (ADDR[23:16] == 8'hE8) && cfgin_q && !cfgout_q;
  assign exec    = (z2_state == Z2_DATA) && autoconfig_cycle && !dtack_q;
  // Writes only take effect while a board is actually being presented
  assign wr      = exec && !RW && (state_q == StPresent);
  assign advance = wr && ((offset == REG_BASE_HI) || (offset == REG_SHUTUP));

  assign first_pick = find_from(board_en, 0);
  assign next_pick  = find_from(board_en, int'(idx_q) + 1);

  ac_read_mux #(
    .MFG_ID     (MFG_ID),
    .SERIAL     (SERIAL),
    .ROM_OFFSET (ROM_OFFSET)
  ) u_read_mux (
    .offset  (offset),
    .is_mem  (BOARD_IS_MEM[idx_q]),
    .has_rom (BOARD_HAS_ROM[idx_q]),
    .size    (BOARD_SIZE[int'(idx_q)*3 +: 3]),
    .prodid  (BOARD_PRODID[int'(idx_q)*8 +: 8]),
    .nibble  (rd_nibble)
  );

  // Next board selection: step to the next enabled board or finish the chain
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (advance) begin
      if (next_pick[IdxW]) begin
        state_d = StPresent;
        idx_d   = next_pick[IdxW-1:0];
      end else begin
        state_d = StDone;
      end
    end
  end

  // FSM state register; reset lands on the lowest enabled board
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= first_pick[IdxW] ? StPresent : StDone;
      idx_q   <= first_pick[IdxW-1:0];
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Bus handshake, read data, chain handoff and base register writes
  always_ff @(posedge CLK) begin
    if (RESET) begin
      dtack_q      <= 1'b0;
      dout_q       <= 4'h0;
      cfgin_q      <= 1'b0;
      cfgout_q     <= 1'b0;
      staged_q     <= 4'h0;
      configured_q <= '0;
      base_q       <= '0;
    end else begin
      if (exec) begin
        dtack_q <= 1'b1;
      end else if (AS_n) begin
        dtack_q <= 1'b0;
      end
      if (exec && RW) dout_q <= rd_nibble;
      // Chain signals only move between bus cycles
      if (AS_n) begin
        cfgin_q  <= CFGIN;
        cfgout_q <= (state_q == StDone);
      end
      if (wr) begin
        case (offset)
          REG_BASE_LO: staged_q <= DIN;
          REG_BASE_HI: begin
            base_q[idx_q]       <= {DIN, staged_q};
            configured_q[idx_q] <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Window decode per board using 9-bit bounds so top-of-space windows hold
  always_comb begin
    board_hit = '0;
    for (int i = 0; i < int'(NUM_BOARDS); i++) begin
      board_hit[i] = configured_q[i] && (addr_hi9 >= {1'b0, base_q[i]}) &&
                     (addr_hi9 < ({1'b0, base_q[i]} + size_to_units(BOARD_SIZE[i*3 +: 3])));
    end
  end

  assign dtack            = dtack_q;
  assign DOUT             = dout_q;
  assign CFGOUT           = cfgout_q;
  assign board_configured = configured_q;

endmodule

// File: tb/tb_autoconfig_chain.sv
// Randomised self-checking bench for autoconfig_chain against a
// transaction-level reference model of the board chain.
module tb_autoconfig_chain;
  import autoconfig_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [23:1] ADDR;
  logic        AS_n;
  logic        RW;
  logic [3:0]  DIN;
  logic [1:0]  z2_state;
  logic        CFGIN;
  logic [2:0]  board_en;
  logic [3:0]  DOUT;
  logic        dtack;
  logic        autoconfig_cycle;
  logic        CFGOUT;
  logic [2:0]  board_configured;
  logic [2:0]  board_hit;

  always #5 CLK = ~CLK;

  autoconfig_chain dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .ADDR             (ADDR),
    .AS_n             (AS_n),
    .RW               (RW),
    .DIN              (DIN),
    .z2_state         (z2_state),
    .CFGIN            (CFGIN),
    .board_en         (board_en),
    .DOUT             (DOUT),
    .dtack            (dtack),
    .autoconfig_cycle (autoconfig_cycle),
    .CFGOUT           (CFGOUT),
    .board_configured (board_configured),
    .board_hit        (board_hit)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (m_idx = -1 means the chain is finished)
  int         m_idx;
  bit         m_cfgin_q, m_cfgout;
  logic [3:0] m_dout, m_staged;
  logic [2:0] m_conf;
  int         m_base[3];

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Board catalogue: 0 = 8MB memory, 1 = 128K IO with ROM, 2 = 64K IO
  function automatic int units_of(input int b);
    case (b)
      0: return 128;
      1: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int m_first(input int from);
    for (int j = from; j < 3; j++) if (board_en[j]) return j;
    return -1;
  endfunction

  function automatic int m_read(input int idx, input int off);
    int is_mem, has_rom, prod, size;
    if (idx < 0) return 15;
    is_mem  = (idx == 0) ? 1 : 0;
    has_rom = (idx == 1) ? 1 : 0;
    prod    = (idx == 0) ? 72 : (idx == 1) ? 6 : 74;
    size    = (idx == 0) ? 0 : (idx == 1) ? 2 : 1;
    if (off == 0) return 12 + 2 * is_mem + has_rom;
    if (off == 1) return size;
    if (off == 2) return 15 - prod / 16;
    if (off == 3) return 15 - prod % 16;
    if (off == 4) return is_mem ? 7 : 15;
    if (off == 5) return 14;
    if (off >= 8 && off <= 11) return 15 - ((2011 >> (4 * (11 - off))) & 15);
    if (off >= 12 && off <= 19) return 15 - ((1 >> (4 * (19 - off))) & 15);
    if (off >= 20 && off <= 23) return has_rom ? 15 - ((8 >> (4 * (23 - off))) & 15) : 15;
    if (off == 32 || off == 33) return 0;
    return 15;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    AS_n     = 1'b1;
    z2_state = Z2_IDLE;
    tick();
    m_cfgin_q = CFGIN;
    m_cfgout  = (m_idx < 0);
  endtask

  task automatic model_reset();
    m_idx     = m_first(0);
    m_cfgin_q = 1'b0;
    m_cfgout  = 1'b0;
    m_dout    = 4'h0;
    m_staged  = 4'h0;
    m_conf    = 3'b000;
    for (int j = 0; j < 3; j++) m_base[j] = 0;
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_dtack", dtack, 0);
    check_eq("rst_dout", DOUT, 0);
    check_eq("rst_cfgout", CFGOUT, 0);
    check_eq("rst_configured", board_configured, 0);
  endtask

  task automatic do_reset(input logic [2:0] en);
    board_en = en;
    RESET    = 1'b1;
    AS_n     = 1'b1;
    z2_state = Z2_IDLE;
    tick();
    RESET = 1'b0;
    model_reset();
    check_reset_outputs();
    idle();
  endtask

  task automatic access(input logic [7:0] hi, input logic [7:0] off, input logic rw,
                        input logic [3:0] din);
    bit ack;
    ADDR     = {hi, 7'($urandom), off};
    RW       = rw;
    DIN      = din;
    AS_n     = 1'b0;
    z2_state = Z2_DATA;
    ack      = (hi == 8'hE8) && m_cfgin_q && !m_cfgout;
    tick();
    check_eq("dtack", dtack, ack);
    if (ack) begin
      if (rw) begin
        m_dout = 4'(m_read(m_idx, int'(off)));
      end else if (m_idx >= 0) begin
        if (off == 8'h25) begin
          m_staged = din;
        end else if (off == 8'h24) begin
          m_base[m_idx] = int'(din) * 16 + int'(m_staged);
          m_conf[m_idx] = 1'b1;
          m_idx = m_first(m_idx + 1);
        end else if (off == 8'h26) begin
          m_idx = m_first(m_idx + 1);
        end
      end
    end
    if (rw) check_eq("dout", DOUT, m_dout);
    tick();
    check_eq("dtack_hold", dtack, ack);
    idle();
    check_eq("dtack_drop", dtack, 0);
    check_eq("cfgout", CFGOUT, m_cfgout);
    check_eq("configured", board_configured, m_conf);
  endtask

  task automatic probe(input int a);
    logic [2:0] exp;
    ADDR = {8'(a), 15'($urandom)};
    #1;
    for (int j = 0; j < 3; j++)
      exp[j] = m_conf[j] && (a >= m_base[j]) && (a < m_base[j] + units_of(j));
    check_eq("hit", board_hit, exp);
    check_eq("ac_cycle", autoconfig_cycle, (a == 8'hE8) && m_cfgin_q && !m_cfgout);
  endtask

  initial begin
    RESET = 1'b0; ADDR = '0; AS_n = 1'b1; RW = 1'b1; DIN = '0;
    z2_state = Z2_IDLE; CFGIN = 1'b0; board_en = 3'b111;

    // Chain not yet our turn, then our turn
    do_reset(3'b111);
    access(8'hE8, 8'h00, 1'b1, 4'h0);
    CFGIN = 1'b1;
    idle();
    access(8'hE8, 8'h00, 1'b1, 4'h0);
    check_eq("tp_type_b0", DOUT, 4'hE);

    // Board 0 disabled: board 1 presented first
    do_reset(3'b110);
    access(8'hE8, 8'h00, 1'b1, 4'h0);
    check_eq("tp_type_b1", DOUT, 4'hD);
    access(8'hE8, 8'h17, 1'b1, 4'h0);
    check_eq("tp_rom_lo", DOUT, 4'h7);
    access(8'hE8, 8'h02, 1'b1, 4'h0);
    access(8'hE8, 8'h25, 1'b0, 4'h0);
    access(8'hE8, 8'h24, 1'b0, 4'hE);
    check_eq("tp_conf_b1", board_configured, 3'b010);
    probe(8'hE0); probe(8'hE1); probe(8'hE2);

    // Shut-up board 0, configure 1 and 2 (board 2 at top of space)
    do_reset(3'b111);
    access(8'hE8, 8'h26, 1'b0, 4'h0);
    access(8'hE8, 8'h25, 1'b0, 4'h0);
    access(8'hE8, 8'h24, 1'b0, 4'hE);
    access(8'hE8, 8'h25, 1'b0, 4'hF);
    access(8'hE8, 8'h24, 1'b0, 4'hF);
    check_eq("tp_cfgout_done", CFGOUT, 1);
    access(8'hE8, 8'h00, 1'b1, 4'h0);
    probe(8'hFF); probe(8'h00); probe(8'hFE);

    // 8MB board at 0x20
    do_reset(3'b111);
    access(8'hE8, 8'h24, 1'b0, 4'h2);
    probe(8'h1F); probe(8'h20); probe(8'h9F); probe(8'hA0);

    // Reset during an acknowledged cycle
    ADDR = {8'hE8, 7'd0, 8'h00}; RW = 1'b1; AS_n = 1'b0; z2_state = Z2_DATA;
    tick();
    check_eq("mid_dtack", dtack, 1);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    model_reset();
    check_reset_outputs();
    idle();
    access(8'hE8, 8'h00, 1'b1, 4'h0);

    // Randomised scenarios
    for (int s = 0; s < 30; s++) begin
      CFGIN = ($urandom_range(0, 7) != 0);
      do_reset(3'($urandom));
      for (int k = 0; k < 20; k++) begin
        case ($urandom_range(0, 9))
          0, 1, 2: access(8'hE8, 8'($urandom_range(0, 63)), 1'b1, 4'h0);
          3: access(8'hE8, 8'h25, 1'b0, 4'($urandom));
          4: access(8'hE8, 8'h24, 1'b0, 4'($urandom));
          5: if ($urandom_range(0, 1) == 0) access(8'hE8, 8'h26, 1'b0, 4'h0);
             else access(8'hE8, 8'($urandom_range(0, 63)), 1'b0, 4'($urandom));
          6: begin
            int b;
            b = $urandom_range(0, 2);
            probe($urandom_range(0, 255));
            probe(m_base[b] - 1 < 0 ? 0 : m_base[b] - 1);
            probe(m_base[b]);
            probe(m_base[b] + units_of(b) - 1 > 255 ? 255 : m_base[b] + units_of(b) - 1);
            probe(m_base[b] + units_of(b) > 255 ? 255 : m_base[b] + units_of(b));
          end
          7: board_en = 3'($urandom);
          8: begin
            CFGIN = ($urandom_range(0, 3) != 0);
            idle();
          end
          default: access(8'($urandom), 8'($urandom_range(0, 63)), 1'($urandom), 4'($urandom));
        endcase
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
